// File: rtl/sliding_threshold_detector.sv
// Streaming k-of-n detector: keeps the last WINDOW accepted bits and flags when at least
// THRESH of them are 1, with a sticky hit flag cleared only by clear or rst.
module sliding_threshold_detector #(
  parameter int unsigned WINDOW = 3,
  parameter int unsigned THRESH = 2,
  localparam int unsigned CW = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_val,
  input  logic          in_bit,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          out,
  output logic          hit
);

  localparam logic [CW-1:0] WinC = CW'(WINDOW);
  localparam logic [CW-1:0] ThrC = CW'(THRESH);

  logic [WINDOW-1:0] win_q, win_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic [CW-1:0]     count_q, count_d;
  logic              hit_q, hit_d;
  logic              full_q;
  logic              out_next;

  assign full_q = (fill_q == WinC);

  always_comb begin
    win_d    = win_q;
    fill_d   = fill_q;
    count_d  = count_q;
    if (clear) begin
      win_d   = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (in_val) begin
      win_d = (win_q << 1) | WINDOW'(in_bit);
      if (full_q) begin
        // Evicted bit was already counted, so this can neither overflow nor underflow.
        count_d = count_q + CW'(in_bit) - CW'(win_q[WINDOW-1]);
      end else begin
        fill_d  = fill_q + CW'(1);
        count_d = count_q + CW'(in_bit);
      end
    end
    out_next = (fill_d == WinC) && (count_d >= ThrC);
    hit_d    = !clear && (hit_q || out_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= '0;
      fill_q  <= '0;
      count_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      win_q   <= win_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign out   = full_q && (count_q >= ThrC);
  assign hit   = hit_q;

endmodule

// File: tb/tb_sliding_threshold_detector.sv
// Directed self-checking bench: four detector configurations share one stimulus stream,
// each scenario checks the instance whose parameters it targets.
module tb_sliding_threshold_detector;

  logic clk = 1'b0;
  logic rst, in_val, in_bit, clear;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [1:0] d3_count;
  logic       d3_full, d3_out, d3_hit;
  logic [3:0] d8_count;
  logic       d8_full, d8_out, d8_hit;
  logic [2:0] d4_count;
  logic       d4_full, d4_out, d4_hit;
  logic [0:0] d1_count;
  logic       d1_full, d1_out, d1_hit;

  always #5 clk = ~clk;

  sliding_threshold_detector u_d3 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_bit(in_bit), .clear(clear),
    .count(d3_count), .full(d3_full), .out(d3_out), .hit(d3_hit)
  );

  sliding_threshold_detector #(.WINDOW(8), .THRESH(8)) u_d8 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_bit(in_bit), .clear(clear),
    .count(d8_count), .full(d8_full), .out(d8_out), .hit(d8_hit)
  );

  sliding_threshold_detector #(.WINDOW(4), .THRESH(1)) u_d4 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_bit(in_bit), .clear(clear),
    .count(d4_count), .full(d4_full), .out(d4_out), .hit(d4_hit)
  );

  sliding_threshold_detector #(.WINDOW(1), .THRESH(1)) u_d1 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_bit(in_bit), .clear(clear),
    .count(d1_count), .full(d1_full), .out(d1_out), .hit(d1_hit)
  );

  // One clock of stimulus; returns 1 time unit after the edge, ready for sampling.
  task automatic step(input logic v, input logic b, input logic c);
    in_val = v;
    in_bit = b;
    clear  = c;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    in_bit = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_val = 1'b0; in_bit = 1'b0; clear = 1'b0;
    #2;
    n_checks++;
    if ({d3_count, d3_full, d3_out, d3_hit} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_d3: got cnt=%0d full=%b out=%b hit=%b required all 0",
               d3_count, d3_full, d3_out, d3_hit);
    end
    n_checks++;
    if ({d8_count, d8_full, d8_out, d8_hit} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_d8: got cnt=%0d full=%b out=%b hit=%b required all 0",
               d8_count, d8_full, d8_out, d8_hit);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({d3_count, d3_full, d3_out, d3_hit} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got cnt=%0d full=%b out=%b hit=%b required all 0",
               d3_count, d3_full, d3_out, d3_hit);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] maj;
    logic [1:0] pop [8];
    logic [2:0] pv;
    maj = 8'b1110_1000;
    pop = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    for (int p = 0; p < 8; p++) begin
      pv = 3'(p);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, pv[2], 1'b0);
      n_checks++;
      if (d3_out !== 1'b0 || d3_full !== 1'b0) begin
        n_fail++;
        $display("FAIL pattern_first p=%0d: got out=%b full=%b required 0 0", p, d3_out, d3_full);
      end
      step(1'b1, pv[1], 1'b0);
      n_checks++;
      if (d3_out !== 1'b0 || d3_full !== 1'b0) begin
        n_fail++;
        $display("FAIL pattern_second p=%0d: got out=%b full=%b required 0 0", p, d3_out, d3_full);
      end
      step(1'b1, pv[0], 1'b0);
      n_checks++;
      if (d3_out !== maj[p] || d3_count !== pop[p] || d3_full !== 1'b1) begin
        n_fail++;
        $display("FAIL pattern_third p=%0d: got out=%b cnt=%0d full=%b required %b %0d 1",
                 p, d3_out, d3_count, d3_full, maj[p], pop[p]);
      end
    end
  endtask

  task automatic test_sliding();
    logic [7:0] bits, exp_out, exp_hit;
    // Index 0 is the first accept.
    bits    = 8'b0111_0011;
    exp_out = 8'b1110_0100;
    exp_hit = 8'b1111_1100;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, bits[i], 1'b0);
      n_checks++;
      if (d3_out !== exp_out[i] || d3_hit !== exp_hit[i]) begin
        n_fail++;
        $display("FAIL sliding i=%0d: got out=%b hit=%b required %b %b",
                 i, d3_out, d3_hit, exp_out[i], exp_hit[i]);
      end
    end
    n_checks++;
    if (d3_count !== 2'd2) begin
      n_fail++;
      $display("FAIL sliding_count: got %0d required 2", d3_count);
    end
  endtask

  task automatic test_gaps();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (d3_count !== 2'd1 || d3_full !== 1'b0) begin
        n_fail++;
        $display("FAIL gap1 i=%0d: got cnt=%0d full=%b required 1 0", i, d3_count, d3_full);
      end
    end
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (d3_count !== 2'd2 || d3_full !== 1'b0 || d3_out !== 1'b0) begin
        n_fail++;
        $display("FAIL gap2 i=%0d: got cnt=%0d full=%b out=%b required 2 0 0",
                 i, d3_count, d3_full, d3_out);
      end
    end
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (d3_count !== 2'd2 || d3_full !== 1'b1 || d3_out !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_final: got cnt=%0d full=%b out=%b required 2 1 1",
               d3_count, d3_full, d3_out);
    end
  endtask

  task automatic test_clear_priority();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (d3_out !== 1'b1 || d3_hit !== 1'b1 || d3_count !== 2'd3) begin
      n_fail++;
      $display("FAIL clear_pre: got out=%b hit=%b cnt=%0d required 1 1 3",
               d3_out, d3_hit, d3_count);
    end
    step(1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({d3_count, d3_full, d3_out, d3_hit} !== 5'b0) begin
      n_fail++;
      $display("FAIL clear_post: got cnt=%0d full=%b out=%b hit=%b required all 0",
               d3_count, d3_full, d3_out, d3_hit);
    end
    // Fill must restart from zero: one accept leaves the window not full.
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (d3_count !== 2'd1 || d3_full !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_refill: got cnt=%0d full=%b required 1 0", d3_count, d3_full);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (d8_out !== 1'b0 || d8_count !== 4'd7) begin
      n_fail++;
      $display("FAIL w8_seven: got out=%b cnt=%0d required 0 7", d8_out, d8_count);
    end
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (d8_out !== 1'b1 || d8_hit !== 1'b1 || d8_count !== 4'd8) begin
      n_fail++;
      $display("FAIL w8_eight: got out=%b hit=%b cnt=%0d required 1 1 8",
               d8_out, d8_hit, d8_count);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({d8_count, d8_full, d8_out, d8_hit} !== 7'b0) begin
      n_fail++;
      $display("FAIL w8_async_rst: got cnt=%0d full=%b out=%b hit=%b required all 0",
               d8_count, d8_full, d8_out, d8_hit);
    end
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (d8_out !== 1'b0 || d8_full !== 1'b0 || d8_count !== 4'd7) begin
      n_fail++;
      $display("FAIL w8_refill7: got out=%b full=%b cnt=%0d required 0 0 7",
               d8_out, d8_full, d8_count);
    end
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (d8_out !== 1'b1 || d8_full !== 1'b1) begin
      n_fail++;
      $display("FAIL w8_refill8: got out=%b full=%b required 1 1", d8_out, d8_full);
    end
  endtask

  task automatic test_eviction();
    logic [4:0] bits, exp_out;
    logic [2:0] exp_cnt [5];
    bits    = 5'b00001;
    exp_out = 5'b01000;
    exp_cnt = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bits[i], 1'b0);
      n_checks++;
      if (d4_out !== exp_out[i] || d4_count !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL w4_evict i=%0d: got out=%b cnt=%0d required %b %0d",
                 i, d4_out, d4_count, exp_out[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_window1();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (d1_out !== 1'b1 || d1_full !== 1'b1 || d1_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL w1_one: got out=%b full=%b hit=%b required 1 1 1", d1_out, d1_full, d1_hit);
    end
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (d1_out !== 1'b0 || d1_count !== 1'b0 || d1_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL w1_zero: got out=%b cnt=%0d hit=%b required 0 0 1",
               d1_out, d1_count, d1_hit);
    end
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (d1_out !== 1'b0) begin
      n_fail++;
      $display("FAIL w1_idle: got out=%b required 0", d1_out);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_sliding();
    test_gaps();
    test_clear_priority();
    test_async_reset();
    test_eviction();
    test_window1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
